// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT magnitude streaming block.
package fft_pkg;

    localparam int NSamples = 1024;
    localparam int DW       = 16;
    localparam int W        = 2 * DW + 1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } fft_stream_state_t;

    typedef logic [W-1:0] mag_t;

endpackage

// File: rtl/cplx_mag_sq.sv
// Two-stage |z|^2 pipeline: stage 1 squares re and im, stage 2 sums them.
// Valid and last travel alongside the data as a sideband.
module cplx_mag_sq #(
    parameter int DW = 16,
    parameter int W  = 2 * DW + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [DW-1:0] re_i,
    input  logic signed [DW-1:0] im_i,
    input  logic                 valid_i,
    input  logic                 last_i,
    output logic [W-1:0]         mag_o,
    output logic                 valid_o,
    output logic                 last_o
);

    logic signed [2*DW-1:0] re_ext_s;
    logic signed [2*DW-1:0] im_ext_s;
    logic [2*DW-1:0]        re_sq_d;
    logic [2*DW-1:0]        im_sq_d;
    logic [2*DW-1:0]        re_sq_q;
    logic [2*DW-1:0]        im_sq_q;
    logic                   v1_q;
    logic                   l1_q;
    logic [W-1:0]           mag_d;
    logic [W-1:0]           mag_q;
    logic                   v2_q;
    logic                   l2_q;

    // Sign-extend before squaring so the full 2*DW product is kept; the square
    // of a signed value is never negative, so it is carried as unsigned.
    always_comb begin
        re_ext_s = (2*DW)'(re_i);
        im_ext_s = (2*DW)'(im_i);
        re_sq_d  = $unsigned(re_ext_s * re_ext_s);
        im_sq_d  = $unsigned(im_ext_s * im_ext_s);
        mag_d    = {{(W-2*DW){1'b0}}, re_sq_q} + {{(W-2*DW){1'b0}}, im_sq_q};
    end

    // Stage 1: register the two squares for accepted bins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            re_sq_q <= {(2*DW){1'b0}};
            im_sq_q <= {(2*DW){1'b0}};
            v1_q    <= 1'b0;
            l1_q    <= 1'b0;
        end else begin
            v1_q <= valid_i;
            l1_q <= valid_i & last_i;
            if (valid_i) begin
                re_sq_q <= re_sq_d;
                im_sq_q <= im_sq_d;
            end
        end
    end

    // Stage 2: register the sum; mag holds its last value between frames.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mag_q <= {W{1'b0}};
            v2_q  <= 1'b0;
            l2_q  <= 1'b0;
        end else begin
            v2_q <= v1_q;
            l2_q <= v1_q & l1_q;
            if (v1_q) begin
                mag_q <= mag_d;
            end
        end
    end

    assign mag_o   = mag_q;
    assign valid_o = v2_q;
    assign last_o  = l2_q;

endmodule

// File: rtl/fft_mag_stream.sv
// Frame-tracking front end for the spectral peak finder: accepts one FFT bin
// per cycle, enforces exactly NSamples bins per frame and reports aborts.
module fft_mag_stream #(
    parameter int NSamples = fft_pkg::NSamples,
    parameter int DW       = fft_pkg::DW,
    parameter int W        = 2 * DW + 1,
    parameter int NBits    = $clog2(NSamples)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [DW-1:0] fft_re,
    input  logic signed [DW-1:0] fft_im,
    input  logic                 fft_valid,
    input  logic                 fft_sop,
    input  logic                 fft_eop,
    output logic [W-1:0]         mag,
    output logic                 mag_valid,
    output logic                 mag_last,
    output logic                 frame_err
);

    import fft_pkg::*;

    localparam logic [NBits-1:0] LastIdx = NBits'(NSamples - 1);

    fft_stream_state_t state_q;
    fft_stream_state_t state_d;
    logic [NBits-1:0]  count_q;
    logic [NBits-1:0]  count_d;
    logic              frame_err_q;
    logic              err_d;
    logic              acc_s;
    logic              last_s;

    // Frame FSM: decide acceptance, last-bin marking and abort conditions.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_s   = 1'b0;
        last_s  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (fft_valid && fft_sop) begin
                    acc_s = 1'b1;
                    if (fft_eop) begin
                        // eop on bin 0 ends the frame far too early
                        err_d = 1'b1;
                    end else begin
                        state_d = STREAM;
                        count_d = NBits'(1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (!fft_valid || fft_sop) begin
                    // gap or unexpected sop: drop this bin, abort the frame
                    err_d   = 1'b1;
                    state_d = IDLE;
                    count_d = {NBits{1'b0}};
                end else begin
                    acc_s = 1'b1;
                    if (count_q == LastIdx) begin
                        last_s  = 1'b1;
                        err_d   = ~fft_eop;
                        state_d = IDLE;
                        count_d = {NBits{1'b0}};
                    end else if (fft_eop) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                        count_d = {NBits{1'b0}};
                    end else begin
                        count_d = count_q + NBits'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                count_d = {NBits{1'b0}};
            end
        endcase
    end

    // State, bin counter and error pulse registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            count_q     <= {NBits{1'b0}};
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            frame_err_q <= err_d;
        end
    end

    cplx_mag_sq #(
        .DW (DW),
        .W  (W)
    ) u_mag_sq (
        .clk     (clk),
        .reset   (reset),
        .re_i    (fft_re),
        .im_i    (fft_im),
        .valid_i (acc_s),
        .last_i  (last_s),
        .mag_o   (mag),
        .valid_o (mag_valid),
        .last_o  (mag_last)
    );

    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_fft_mag_stream.sv
// Self-checking bench for fft_mag_stream: a frame-level reference model
// predicts every output cycle; scenario tasks add spec-level count checks.
module tb_fft_mag_stream;

    localparam int N    = 1024;
    localparam int MAXC = 16384;

    logic               clk = 1'b1;
    logic               reset;
    logic signed [15:0] fft_re;
    logic signed [15:0] fft_im;
    logic               fft_valid;
    logic               fft_sop;
    logic               fft_eop;
    logic [32:0]        mag;
    logic               mag_valid;
    logic               mag_last;
    logic               frame_err;

    always #5 clk = ~clk;

    fft_mag_stream dut (
        .clk       (clk),
        .reset     (reset),
        .fft_re    (fft_re),
        .fft_im    (fft_im),
        .fft_valid (fft_valid),
        .fft_sop   (fft_sop),
        .fft_eop   (fft_eop),
        .mag       (mag),
        .mag_valid (mag_valid),
        .mag_last  (mag_last),
        .frame_err (frame_err)
    );

    int n_vec = 0;
    int n_err = 0;
    int cur   = 0;

    logic [32:0] exp_m [MAXC];
    bit          exp_v [MAXC];
    bit          exp_l [MAXC];
    bit          exp_e [MAXC];
    bit          exp_z [MAXC];
    logic [32:0] obs_m [MAXC];
    logic        obs_v [MAXC];
    logic        obs_l [MAXC];
    logic        obs_e [MAXC];

    // reference model state: inside a frame, and the index of the next bin
    bit m_in_frame = 1'b0;
    int m_idx      = 0;

    // Apply one cycle of inputs, predict its effects, record the outputs.
    task automatic drive(input bit rn, input bit v, input bit s, input bit e,
                         input int re, input int im);
        longint lr, li;
        bit acc, lst, err;
        int bin;
        if (cur + 2 >= MAXC) begin
            $display("FAIL cycle_budget: cycle %0d exceeds table size %0d", cur, MAXC);
            $fatal(1);
        end
        reset     = rn;
        fft_valid = v;
        fft_sop   = s;
        fft_eop   = e;
        fft_re    = 16'(re);
        fft_im    = 16'(im);
        lr  = longint'(fft_re);
        li  = longint'(fft_im);
        acc = 1'b0;
        lst = 1'b0;
        err = 1'b0;
        bin = 0;
        if (!rn) begin
            // reset kills the bin in flight and everything upstream of it
            m_in_frame = 1'b0;
            m_idx      = 0;
            exp_v[cur+1] = 1'b0;
            exp_l[cur+1] = 1'b0;
            exp_m[cur+1] = 33'd0;
        end else begin
            if (!m_in_frame) begin
                if (v && s) begin
                    acc = 1'b1;
                    bin = 0;
                end
            end else if (!v || s) begin
                err = 1'b1;
                m_in_frame = 1'b0;
            end else begin
                acc = 1'b1;
                bin = m_idx;
            end
            if (acc) begin
                lst = (bin == N - 1);
                if (bin == N - 1) begin
                    m_in_frame = 1'b0;
                    err = !e;
                end else if (e) begin
                    m_in_frame = 1'b0;
                    err = 1'b1;
                end else begin
                    m_in_frame = 1'b1;
                    m_idx = bin + 1;
                end
            end
        end
        exp_e[cur+1] = err;
        exp_z[cur+1] = !rn;
        exp_v[cur+2] = acc;
        exp_l[cur+2] = lst;
        exp_m[cur+2] = 33'(lr * lr + li * li);
        @(negedge clk);
        obs_m[cur] = mag;
        obs_v[cur] = mag_valid;
        obs_l[cur] = mag_last;
        obs_e[cur] = frame_err;
        @(posedge clk);
        #1;
        cur++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic test_reset();
        int s, nv;
        s = cur;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, rnd16(), rnd16());
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, rnd16(), rnd16());
        idle(2);
        for (int c = s + 1; c <= s + 3; c++) begin
            n_vec++;
            if (obs_v[c] !== 1'b0 || obs_l[c] !== 1'b0 || obs_e[c] !== 1'b0 || obs_m[c] !== 33'd0) begin
                n_err++;
                $display("FAIL reset_hold cyc %0d: v=%b l=%b e=%b mag=%h, want all 0", c, obs_v[c], obs_l[c], obs_e[c], obs_m[c]);
            end
        end
        nv = 0;
        for (int c = s + 1; c < cur; c++) nv += int'(obs_v[c] === 1'b1);
        n_vec++;
        if (nv != 0) begin
            n_err++;
            $display("FAIL reset_no_sop: %0d mag_valid cycles, want 0", nv);
        end
        for (int c = s + 1; c < cur; c++) begin
            n_vec++;
            if (obs_v[c] !== exp_v[c] || obs_l[c] !== exp_l[c] || obs_e[c] !== exp_e[c] ||
                ((exp_v[c] || exp_z[c]) && obs_m[c] !== exp_m[c])) begin
                n_err++;
                $display("FAIL reset_model cyc %0d: got v%b l%b e%b m%h want v%b l%b e%b m%h", c,
                         obs_v[c], obs_l[c], obs_e[c], obs_m[c], exp_v[c], exp_l[c], exp_e[c], exp_m[c]);
            end
        end
    endtask

    task automatic test_single_frame();
        int s, nv, nl, ne;
        s = cur;
        for (int i = 0; i < N; i++) drive(1'b1, 1'b1, i == 0, i == N - 1, 3, -4);
        idle(3);
        nv = 0; nl = 0; ne = 0;
        for (int c = s; c < cur; c++) begin
            nv += int'(obs_v[c] === 1'b1);
            nl += int'(obs_l[c] === 1'b1);
            ne += int'(obs_e[c] === 1'b1);
            if (obs_v[c] === 1'b1) begin
                n_vec++;
                if (obs_m[c] !== 33'd25) begin
                    n_err++;
                    $display("FAIL single_mag cyc %0d: got %0d want 25", c, obs_m[c]);
                end
            end
        end
        n_vec += 4;
        if (nv != N) begin n_err++; $display("FAIL single_count: %0d outputs want %0d", nv, N); end
        if (obs_v[s+2] !== 1'b1 || obs_v[s+1] !== 1'b0) begin
            n_err++; $display("FAIL single_latency: v@+1=%b v@+2=%b want 0,1", obs_v[s+1], obs_v[s+2]);
        end
        if (nl != 1 || obs_l[s+N+1] !== 1'b1) begin
            n_err++; $display("FAIL single_last: %0d pulses, at last bin %b, want 1,1", nl, obs_l[s+N+1]);
        end
        if (ne != 0) begin n_err++; $display("FAIL single_err: %0d pulses want 0", ne); end
    endtask

    task automatic test_extremes();
        int s;
        s = cur;
        drive(1'b1, 1'b1, 1'b1, 1'b0, -32768, -32768);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32767, -32768);
        idle(3);
        n_vec += 3;
        if (obs_m[s+2] !== 33'h0_8000_0000 || obs_v[s+2] !== 1'b1) begin
            n_err++; $display("FAIL extreme_max: got %h v%b want 080000000 v1", obs_m[s+2], obs_v[s+2]);
        end
        if (obs_m[s+3] !== 33'd0 || obs_v[s+3] !== 1'b1) begin
            n_err++; $display("FAIL extreme_zero: got %h v%b want 0 v1", obs_m[s+3], obs_v[s+3]);
        end
        if (obs_m[s+4] !== 33'd2147418113) begin
            n_err++; $display("FAIL extreme_mixed: got %0d want 2147418113", obs_m[s+4]);
        end
        for (int c = s; c < cur; c++) begin
            n_vec++;
            if (obs_v[c] !== exp_v[c] || obs_l[c] !== exp_l[c] || obs_e[c] !== exp_e[c] ||
                (exp_v[c] && obs_m[c] !== exp_m[c])) begin
                n_err++;
                $display("FAIL extreme_model cyc %0d: got v%b l%b e%b m%h want v%b l%b e%b m%h", c,
                         obs_v[c], obs_l[c], obs_e[c], obs_m[c], exp_v[c], exp_l[c], exp_e[c], exp_m[c]);
            end
        end
    endtask

    // Shared shape for abort scenarios: frame of nbins, then gap/extra bins.
    task automatic test_gap_abort();
        int s, nv, ne;
        s = cur;
        for (int i = 0; i < 500; i++) drive(1'b1, 1'b1, i == 0, 1'b0, rnd16(), rnd16());
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, rnd16(), rnd16());
        idle(3);
        nv = 0; ne = 0;
        for (int c = s; c < cur; c++) begin
            nv += int'(obs_v[c] === 1'b1);
            ne += int'(obs_e[c] === 1'b1);
            n_vec++;
            if (obs_v[c] !== exp_v[c] || obs_l[c] !== exp_l[c] || obs_e[c] !== exp_e[c] ||
                (exp_v[c] && obs_m[c] !== exp_m[c])) begin
                n_err++;
                $display("FAIL gap_model cyc %0d: got v%b l%b e%b m%h want v%b l%b e%b m%h", c,
                         obs_v[c], obs_l[c], obs_e[c], obs_m[c], exp_v[c], exp_l[c], exp_e[c], exp_m[c]);
            end
        end
        n_vec += 2;
        if (nv != 500) begin n_err++; $display("FAIL gap_count: %0d outputs want 500", nv); end
        if (ne != 1 || obs_e[s+501] !== 1'b1) begin
            n_err++; $display("FAIL gap_err: %0d pulses, at gap+1 %b, want 1,1", ne, obs_e[s+501]);
        end
    endtask

    task automatic test_eop_errors();
        int s, nv, ne;
        // eop on bin 10
        s = cur;
        for (int i = 0; i <= 10; i++) drive(1'b1, 1'b1, i == 0, i == 10, rnd16(), rnd16());
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, rnd16(), rnd16());
        idle(3);
        nv = 0; ne = 0;
        for (int c = s; c < cur; c++) begin
            nv += int'(obs_v[c] === 1'b1);
            ne += int'(obs_e[c] === 1'b1);
        end
        n_vec += 2;
        if (nv != 11) begin n_err++; $display("FAIL early_eop_count: %0d outputs want 11", nv); end
        if (ne != 1 || obs_e[s+11] !== 1'b1) begin
            n_err++; $display("FAIL early_eop_err: %0d pulses, at bin10+1 %b, want 1,1", ne, obs_e[s+11]);
        end
        // no eop on the last bin
        for (int i = 0; i < N; i++) drive(1'b1, 1'b1, i == 0, 1'b0, rnd16(), rnd16());
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, rnd16(), rnd16());
        idle(3);
        nv = 0; ne = 0;
        for (int c = s + 34; c < cur; c++) begin
            nv += int'(obs_v[c] === 1'b1);
            ne += int'(obs_e[c] === 1'b1);
        end
        n_vec += 2;
        if (nv != N) begin n_err++; $display("FAIL late_eop_count: %0d outputs want %0d", nv, N); end
        if (ne != 1 || obs_e[s+34+N] !== 1'b1) begin
            n_err++; $display("FAIL late_eop_err: %0d pulses, at last+1 %b, want 1,1", ne, obs_e[s+34+N]);
        end
        for (int c = s; c < cur; c++) begin
            n_vec++;
            if (obs_v[c] !== exp_v[c] || obs_l[c] !== exp_l[c] || obs_e[c] !== exp_e[c] ||
                (exp_v[c] && obs_m[c] !== exp_m[c])) begin
                n_err++;
                $display("FAIL eop_model cyc %0d: got v%b l%b e%b m%h want v%b l%b e%b m%h", c,
                         obs_v[c], obs_l[c], obs_e[c], obs_m[c], exp_v[c], exp_l[c], exp_e[c], exp_m[c]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int s, run, best, ne, nl, l1, l2;
        s = cur;
        for (int i = 0; i < 2 * N; i++)
            drive(1'b1, 1'b1, (i % N) == 0, (i % N) == N - 1, rnd16(), rnd16());
        idle(3);
        run = 0; best = 0; ne = 0; nl = 0; l1 = -1; l2 = -1;
        for (int c = s; c < cur; c++) begin
            run  = (obs_v[c] === 1'b1) ? run + 1 : 0;
            best = (run > best) ? run : best;
            ne  += int'(obs_e[c] === 1'b1);
            if (obs_l[c] === 1'b1) begin
                nl++;
                if (l1 < 0) l1 = c; else l2 = c;
            end
            n_vec++;
            if (obs_v[c] !== exp_v[c] || obs_l[c] !== exp_l[c] || obs_e[c] !== exp_e[c] ||
                (exp_v[c] && obs_m[c] !== exp_m[c])) begin
                n_err++;
                $display("FAIL b2b_model cyc %0d: got v%b l%b e%b m%h want v%b l%b e%b m%h", c,
                         obs_v[c], obs_l[c], obs_e[c], obs_m[c], exp_v[c], exp_l[c], exp_e[c], exp_m[c]);
            end
        end
        n_vec += 3;
        if (best != 2 * N) begin n_err++; $display("FAIL b2b_run: longest run %0d want %0d", best, 2 * N); end
        if (nl != 2 || l2 - l1 != N) begin
            n_err++; $display("FAIL b2b_last: %0d pulses spacing %0d, want 2 spacing %0d", nl, l2 - l1, N);
        end
        if (ne != 0) begin n_err++; $display("FAIL b2b_err: %0d pulses want 0", ne); end
    endtask

    task automatic test_reset_mid_frame();
        int s, ne, nv;
        s = cur;
        for (int i = 0; i < 50; i++) drive(1'b1, 1'b1, i == 0, 1'b0, rnd16(), rnd16());
        drive(1'b0, 1'b1, 1'b0, 1'b0, rnd16(), rnd16());
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, rnd16(), rnd16());
        idle(2);
        ne = 0; nv = 0;
        for (int c = s; c < cur; c++) begin
            ne += int'(obs_e[c] === 1'b1);
            nv += int'(obs_v[c] === 1'b1);
        end
        n_vec += 2;
        if (ne != 0) begin n_err++; $display("FAIL rst_mid_err: %0d pulses want 0", ne); end
        if (nv != 49) begin n_err++; $display("FAIL rst_mid_count: %0d outputs want 49", nv); end
    endtask

    task automatic test_random();
        int s, k;
        bit rn, v, sp, ep;
        s = cur;
        k = 0;
        for (int i = 0; i < 3000; i++) begin
            rn = ($urandom_range(0, 999) >= 2);
            v  = ($urandom_range(0, 99) < 97);
            sp = (k == 0) || ($urandom_range(0, 299) == 0);
            ep = (k == N - 1) || ($urandom_range(0, 299) == 0);
            drive(rn, v, sp, ep, rnd16(), rnd16());
            if (!rn || $urandom_range(0, 499) == 0) k = 0;
            else if (v) k = (k + 1) % N;
        end
        idle(3);
        for (int c = s; c < cur; c++) begin
            n_vec++;
            if (obs_v[c] !== exp_v[c] || obs_l[c] !== exp_l[c] || obs_e[c] !== exp_e[c] ||
                ((exp_v[c] || exp_z[c]) && obs_m[c] !== exp_m[c])) begin
                n_err++;
                $display("FAIL random_model cyc %0d: got v%b l%b e%b m%h want v%b l%b e%b m%h", c,
                         obs_v[c], obs_l[c], obs_e[c], obs_m[c], exp_v[c], exp_l[c], exp_e[c], exp_m[c]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_extremes();
        test_gap_abort();
        test_eop_errors();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fft_mag_stream.md
# fft_mag_stream

Streams squared FFT magnitudes into the spectral peak finder. Accepts the FFT core's complex output one bin per cycle, computes re²+im² in a two-stage pipeline, and emits `mag`/`mag_valid` as one unbroken run of exactly `NSamples` values per frame, which is what the peak finder expects. Frame boundaries are tracked with a bin counter. A malformed or interrupted frame is cut short and flagged, so the downstream counter resynchronises on the next frame.

## Interface
Parameters:
- `NSamples`, 1024: FFT points per frame.
- `DW`, 16: width of the signed real/imag inputs.
- `W`, 2*DW+1 (33): width of the unsigned magnitude output.
- `NBits`, $clog2(NSamples): width of the bin counter.

Ports:
- `clk`  in  1: the single clock.
- `reset`  in  1: synchronous, active-low (0 = reset, sampled on `clk` rising edge).
- `fft_re`  in  DW: signed real part.
- `fft_im`  in  DW: signed imaginary part.
- `fft_valid`  in  1: input bin valid this cycle.
- `fft_sop`  in  1: first bin of a frame; qualified by `fft_valid`.
- `fft_eop`  in  1: last bin of a frame; qualified by `fft_valid`.
- `mag`  out  W: re²+im², unsigned.
- `mag_valid`  out  1: `mag` valid.
- `mag_last`  out  1: the current `mag` is bin NSamples-1 of its frame.
- `frame_err`  out  1: one-cycle pulse on an aborted or malformed frame.

## Operation
- FSM states:
  - IDLE: waiting for a frame.
  - STREAM: forwarding bins.
- Transitions:
  - IDLE → STREAM on `fft_valid && fft_sop`. That bin is accepted as bin 0 and sets count=1.
  - In IDLE, valid bins without `sop` are dropped silently.
  - In STREAM, each `fft_valid` bin is accepted and increments count.
  - Normal end: the bin at count==NSamples-1 must carry `fft_eop`. It is accepted, the FSM returns to IDLE, and count is cleared.
- Aborts. Each one returns the FSM to IDLE, clears count and pulses `frame_err`:
  - `fft_valid` low while in STREAM. The gap propagates as `mag_valid` low, which resets the peak finder.
  - `fft_sop` in STREAM. The current frame is aborted and the `sop` bin is dropped, not restarted.
  - `fft_eop` at count≠NSamples-1. The `eop` bin itself is still forwarded.
  - count==NSamples-1 without `fft_eop`. The bin is still forwarded.
- After an abort, remaining bins are ignored until the next `sop`.
- Arithmetic:
  - Stage 1 registers re² and im², each signed DW×DW into 2*DW bits, non-negative.
  - Stage 2 registers their sum zero-extended to W bits.
  - Worst case: (-32768)²·2 = 2^31, which fits with no saturation.
- Accepted bins are emitted in order. No reordering and no bit-reversal is applied; bin index semantics belong downstream.
- Reset (`reset`==0): FSM to IDLE, count=0, all pipeline valid bits cleared. Outputs `mag`=0, `mag_valid`=0, `mag_last`=0, `frame_err`=0. Reset overrides all inputs in the same cycle. Reset mid-frame discards in-flight bins, and no `frame_err` is raised.

## Timing
- Throughput is one bin per cycle with no back-pressure.
- Latency: a bin accepted at edge t appears with `mag_valid`=1 after edge t+2.
- `mag_last` is aligned with the `mag` of the final bin, i.e. 2 cycles after the `eop` bin.
- `frame_err` is asserted for one cycle after the edge at which the abort is detected. It is not pipelined with `mag`.
- Back-to-back frames: a `sop` bin in the cycle directly after the normal-end `eop` bin is accepted with no bubble. `mag_valid` stays high across the frame boundary.
- A continuous input frame therefore produces exactly NSamples consecutive `mag_valid` cycles.

## Structure
- Shared package `fft_pkg` holds:
  - constants `NSamples`, `DW`, `W`;
  - FSM typedef `fft_stream_state_t` {IDLE, STREAM};
  - typedef `mag_t` (logic [W-1:0]).
- Sub-module `cplx_mag_sq` holds the two-stage squaring and summing pipeline with a valid/last sideband. The top level holds the FSM, the counter and the error logic.

## Test plan
- Reset hold: `reset`=0 for 3 cycles while driving valid data → all outputs 0; after release with no `sop`, `mag_valid` stays 0.
- Single frame: 1024 bins with re=3, im=-4, `sop` on bin 0 and `eop` on bin 1023 → 1024 consecutive `mag`=25 starting 2 cycles after bin 0, `mag_last` on the 1024th, `frame_err` never set.
- Extremes: re=-32768, im=-32768 → `mag`=33'h0_8000_0000. re=0, im=0 → `mag`=0.
- Gap abort: `fft_valid` low at bin 500 → `mag_valid` drops after 500 outputs, `frame_err` pulses once, and later bins without `sop` produce no output.
- Early/late `eop`: `eop` on bin 10 → 11 outputs then `frame_err`. No `eop` on bin 1023 → 1024 outputs and `frame_err`.
- Back-to-back: two frames with no idle cycle between them → 2048 continuous `mag_valid` cycles and two `mag_last` pulses, 1024 cycles apart.
